quadrature_step_decoder: RTL and testbench

- Upstream stage of the universal up/down counter: converts raw asynchronous quadrature encoder inputs A/B/index into single-cycle counter-control pulses.
- cnt_en, cnt_up and cnt_clr connect directly to the counter's en, up and syn_clr inputs.
- Also detects illegal phase jumps and counts them in a saturating error counter.

---
 rtl/quadrature_step_decoder.sv | 129 ++++++++++++
 tb/tb_quadrature_step_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder front end: synchronize, glitch-filter and decode A/B/index
// into single-cycle up/down counter controls, plus a saturating illegal-step count.
module quadrature_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             idx_in,
    input  logic             idx_arm,
    input  logic             clr_err,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       phase
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] RUN_MAX = CW'(FILT_LEN - 1);

    // Channel bit order everywhere: [2]=index, [1]=A, [0]=B
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  raw;
    logic [2:0]                  synced;
    logic [2:0]                  filt_q;
    logic [2:0]                  filt_d;
    logic [2:0][CW-1:0]          run_q;
    logic [2:0][CW-1:0]          run_d;

    logic [1:0]       phase_q;
    logic [1:0]       ab_new;
    logic [1:0]       diff;
    logic [1:0]       up_nxt;
    logic             step;
    logic             illegal;
    logic             idx_prev_q;
    logic             cnt_en_q;
    logic             cnt_up_q;
    logic             cnt_up_d;
    logic             cnt_clr_q;
    logic             cnt_clr_d;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;

    assign raw    = {idx_in, a_in, b_in};
    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        for (int i = 0; i < 3; i++) begin
            if (synced[i] == filt_q[i]) begin
                run_d[i] = '0;
            end else if (run_q[i] == RUN_MAX) begin
                filt_d[i] = synced[i];
                run_d[i]  = '0;
            end else begin
                run_d[i] = run_q[i] + CW'(1);
            end
        end
    end

    // Successor of the current phase in the A-leads (up) direction
    always_comb begin
        up_nxt = 2'b00;
        unique case (phase_q)
            2'b00: up_nxt = 2'b10;
            2'b10: up_nxt = 2'b11;
            2'b11: up_nxt = 2'b01;
            2'b01: up_nxt = 2'b00;
        endcase
    end

    assign ab_new  = filt_q[1:0];
    assign diff    = ab_new ^ phase_q;
    assign step    = diff[1] ^ diff[0];
    assign illegal = &diff;

    always_comb begin
        cnt_up_d  = step ? (ab_new == up_nxt) : cnt_up_q;
        cnt_clr_d = idx_arm & filt_q[2] & ~idx_prev_q;
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (illegal && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            filt_q      <= '0;
            run_q       <= '0;
            phase_q     <= 2'b00;
            idx_prev_q  <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_up_q    <= 1'b1;
            cnt_clr_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
            filt_q      <= filt_d;
            run_q       <= run_d;
            phase_q     <= ab_new;
            idx_prev_q  <= filt_q[2];
            cnt_en_q    <= step;
            cnt_up_q    <= cnt_up_d;
            cnt_clr_q   <= cnt_clr_d;
            err_pulse_q <= illegal;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_up    = cnt_up_q;
    assign cnt_clr   = cnt_clr_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed and random checks of quadrature_step_decoder against a
// position-arithmetic reference model.
module tb_quadrature_step_decoder;

    localparam int S  = 2;
    localparam int F  = 3;
    localparam int EW = 8;
    localparam logic [1:0] SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_in = 1'b0;
    logic          b_in = 1'b0;
    logic          idx_in = 1'b0;
    logic          idx_arm = 1'b0;
    logic          clr_err = 1'b0;
    logic          cnt_en;
    logic          cnt_up;
    logic          cnt_clr;
    logic          err_pulse;
    logic [EW-1:0] err_cnt;
    logic [1:0]    phase;

    int vectors = 0;
    int miscompares = 0;
    int n_en, n_clr, n_errp;
    int first;

    int m_sync[$];
    int m_filt[3];
    int m_run[3];
    int m_pos;
    int m_errc;
    bit m_en, m_up, m_clr, m_errp, m_idxp;

    quadrature_step_decoder #(
        .SYNC_STAGES(S),
        .FILT_LEN(F),
        .ERR_W(EW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_in(a_in),
        .b_in(b_in),
        .idx_in(idx_in),
        .idx_arm(idx_arm),
        .clr_err(clr_err),
        .cnt_en(cnt_en),
        .cnt_up(cnt_up),
        .cnt_clr(cnt_clr),
        .err_pulse(err_pulse),
        .err_cnt(err_cnt),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input int ab);
        for (int i = 0; i < 4; i++) begin
            if (int'(SEQ[i]) == ab) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_sync.delete();
        repeat (S) m_sync.push_back(0);
        for (int i = 0; i < 3; i++) begin
            m_filt[i] = 0;
            m_run[i]  = 0;
        end
        m_pos  = 0;
        m_errc = 0;
        m_en   = 0;
        m_up   = 1;
        m_clr  = 0;
        m_errp = 0;
        m_idxp = 0;
    endtask

    // One rising edge: quarter-turn position arithmetic on the old filtered value
    task automatic model_edge();
        int sy, np, d;
        sy = m_sync.pop_back();
        m_sync.push_front(int'({idx_in, a_in, b_in}));
        np = pos_of(m_filt[1] * 2 + m_filt[0]);
        d  = (np - m_pos + 4) % 4;
        m_en   = (d == 1) || (d == 3);
        if (d == 1) m_up = 1;
        if (d == 3) m_up = 0;
        m_errp = (d == 2);
        m_pos  = np;
        m_clr  = idx_arm && (m_filt[2] == 1) && !m_idxp;
        m_idxp = (m_filt[2] == 1);
        if (clr_err) m_errc = 0;
        else if (m_errp && m_errc < (2 ** EW) - 1) m_errc++;
        for (int i = 0; i < 3; i++) begin
            if (((sy >> i) & 1) != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] >= F) begin
                    m_filt[i] = (sy >> i) & 1;
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [EW-1:0] ec;
        ec = m_errc[EW-1:0];
        return 32'({m_en, m_up, m_clr, m_errp, SEQ[m_pos], ec});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({cnt_en, cnt_up, cnt_clr, err_pulse, phase, err_cnt});
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        chk("model", dut_vec(), exp_vec());
        n_en   += int'(cnt_en);
        n_clr  += int'(cnt_clr);
        n_errp += int'(err_pulse);
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        n_en   = 0;
        n_clr  = 0;
        n_errp = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), exp_vec());
        chk("reset_up", 32'(cnt_up), 32'd1);
        rst_n = 1'b1;
        hold(4);

        clear_counts();
        a_in = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cnt_en && first == 0) first = k;
        end
        chk("fwd_latency", 32'(first), 32'd6);
        b_in = 1'b1; hold(10);
        a_in = 1'b0; hold(10);
        b_in = 1'b0; hold(10);
        chk("fwd_pulses", 32'(n_en), 32'd4);
        chk("fwd_phase", 32'(phase), 32'd0);
        chk("fwd_up", 32'(cnt_up), 32'd1);

        clear_counts();
        b_in = 1'b1; hold(10);
        a_in = 1'b1; hold(10);
        b_in = 1'b0; hold(10);
        chk("rev_pulses", 32'(n_en), 32'd3);
        chk("rev_up", 32'(cnt_up), 32'd0);
        a_in = 1'b0; hold(10);
        hold(5);
        chk("rev_up_held", 32'(cnt_up), 32'd0);
        chk("rev_err", 32'(err_cnt), 32'd0);

        clear_counts();
        a_in = 1'b1; hold(2);
        a_in = 1'b0; hold(10);
        chk("glitch2_pulses", 32'(n_en), 32'd0);
        chk("glitch2_phase", 32'(phase), 32'd0);
        clear_counts();
        a_in = 1'b1; hold(3);
        a_in = 1'b0; hold(3);
        chk("glitch3_pulses", 32'(n_en), 32'd1);
        hold(10);

        clear_counts();
        a_in = 1'b1;
        b_in = 1'b1;
        hold(10);
        chk("ill_pulses", 32'(n_errp), 32'd1);
        chk("ill_en", 32'(n_en), 32'd0);
        chk("ill_cnt", 32'(err_cnt), 32'd1);
        chk("ill_phase", 32'(phase), 32'd3);
        a_in = 1'b0; b_in = 1'b0; hold(8);
        repeat (149) begin
            a_in = 1'b1; b_in = 1'b1; hold(8);
            a_in = 1'b0; b_in = 1'b0; hold(8);
        end
        chk("ill_saturate", 32'(err_cnt), 32'd255);
        a_in = 1'b1; b_in = 1'b1;
        hold(5);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        hold(5);
        a_in = 1'b0; b_in = 1'b0; hold(10);
        chk("post_clr_cnt", 32'(err_cnt), 32'd1);

        clear_counts();
        idx_arm = 1'b1;
        idx_in = 1'b1; hold(5);
        idx_in = 1'b0; hold(10);
        chk("idx_armed", 32'(n_clr), 32'd1);
        clear_counts();
        idx_arm = 1'b0;
        idx_in = 1'b1; hold(5);
        idx_in = 1'b0; hold(10);
        chk("idx_disarmed", 32'(n_clr), 32'd0);
        idx_arm = 1'b1;
        a_in = 1'b1;
        idx_in = 1'b1;
        hold(5);
        tick();
        chk("idx_coincident", 32'({cnt_en, cnt_clr}), 32'd3);
        idx_in = 1'b0; hold(10);
        a_in = 1'b0; hold(10);

        a_in = 1'b1;
        hold(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_state", dut_vec(), exp_vec());
        tick();
        rst_n = 1'b1;
        first = 0;
        clear_counts();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cnt_en && first == 0) first = k;
        end
        chk("midreset_latency", 32'(first), 32'd6);
        chk("midreset_pulses", 32'(n_en), 32'd1);
        chk("midreset_up", 32'(cnt_up), 32'd1);
        a_in = 1'b0; hold(10);

        repeat (1500) begin
            a_in    = 1'($urandom_range(0, 1));
            b_in    = 1'($urandom_range(0, 1));
            idx_in  = 1'($urandom_range(0, 1));
            idx_arm = 1'($urandom_range(0, 1));
            clr_err = ($urandom_range(0, 15) == 0);
            hold(int'($urandom_range(1, 8)));
        end
        clr_err = 1'b0;
        hold(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
